// File: rtl/antfarm_pkg.sv
// Shared definitions for the ant farm tile map: tile codes, owner tags and
// the sequencer state encoding used by tile_map_arbiter.
package antfarm_pkg;

  localparam logic [2:0] TILE_EMPTY  = 3'd0;
  localparam logic [2:0] TILE_AIR    = 3'd1;
  localparam logic [2:0] TILE_DIRT   = 3'd2;
  localparam logic [2:0] TILE_GROUND = 3'd3;
  localparam logic [2:0] TILE_QUEEN  = 3'd4;
  localparam logic [2:0] TILE_WALL   = 3'd5;
  localparam logic [2:0] TILE_ERROR  = 3'd6;
  localparam logic [2:0] TILE_TUNNEL = 3'd7;

  // Who owns the read data returning from the RAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RD   = 2'd1,
    OWN_ANT  = 2'd2
  } owner_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/tile_map_filler.sv
// Scenario fill sequencer: walks the map row by row and produces one tile
// write per advance. The address is a running counter kept alongside
// row/col so no multiplier is needed.
module tile_map_filler
  import antfarm_pkg::*;
#(
  parameter int MAP_W      = 32,
  parameter int MAP_H      = 24,
  parameter int ADDR_W     = 10,
  parameter int GROUND_ROW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_tile,
  output logic              done
);

  localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int COL_W = $clog2(MAP_W);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(MAP_H - 1);
  localparam logic [ROW_W-1:0] ROW_GND   = ROW_W'(GROUND_ROW);
  localparam logic [ROW_W-1:0] ROW_QUEEN = ROW_W'(GROUND_ROW + 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(MAP_W - 1);
  localparam logic [COL_W-1:0] COL_QUEEN = COL_W'(MAP_W / 2);

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr;

  // Tile precedence: walls first, then the queen, then the layered scenery
  function automatic logic [2:0] tile_at(input logic [ROW_W-1:0] r,
                                         input logic [COL_W-1:0] c);
    logic [2:0] t;
    if (c == '0 || c == COL_LAST)            t = TILE_WALL;
    else if (r == ROW_QUEEN && c == COL_QUEEN) t = TILE_QUEEN;
    else if (r < ROW_GND)                      t = TILE_AIR;
    else if (r == ROW_GND)                     t = TILE_GROUND;
    else                                       t = TILE_DIRT;
    return t;
  endfunction

  assign done    = (row == ROW_LAST) && (col == COL_LAST);
  assign wr_en   = adv;
  assign wr_addr = addr;
  assign wr_tile = tile_at(row, col);

  // Row/column/address walk; everything wraps back to cell 0 after the last cell
  always_ff @(posedge clk) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (adv) begin
      addr <= done ? '0 : addr + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_map_arbiter.sv
// Tile map RAM owner: fills the map after reset, then arbitrates the single
// RAM port between the VGA renderer (priority) and the ant update engine.
// Optional build macro: TILE_ARB_STARVE_EN adds a starvation guard that lets
// the ant engine through after STARVE_MAX consecutive renderer wins.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_INIT | scenario fill, one cell written per cycle, no grants
// ST_RUN  | arbitration between renderer and ant engine
module tile_map_arbiter
  import antfarm_pkg::*;
#(
  parameter int MAP_W      = 32,
  parameter int MAP_H      = 24,
  parameter int ADDR_W     = 10,
  parameter int GROUND_ROW = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        ram_wdata,
  input  logic [2:0]        ram_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [2:0]        rd_data,
  input  logic              ant_req,
  input  logic              ant_we,
  input  logic [ADDR_W-1:0] ant_addr,
  input  logic [2:0]        ant_wdata,
  output logic              ant_gnt,
  output logic              ant_valid,
  output logic [2:0]        ant_rdata,
  output logic              init_done
);

  arb_state_t state, state_next;
  owner_t     owner;
  logic       starve_due;

  logic              fill_wr_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [2:0]        fill_tile;
  logic              fill_done;

  tile_map_filler #(
    .MAP_W      (MAP_W),
    .MAP_H      (MAP_H),
    .ADDR_W     (ADDR_W),
    .GROUND_ROW (GROUND_ROW)
  ) u_filler (
    .clk     (clk),
    .rst     (rst),
    .adv     (state == ST_INIT),
    .wr_en   (fill_wr_en),
    .wr_addr (fill_addr),
    .wr_tile (fill_tile),
    .done    (fill_done)
  );

`ifdef TILE_ARB_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_cnt;

  assign starve_due = (starve_cnt == STARVE_W'(STARVE_MAX));

  // Count renderer wins while the ant engine waits; any ant win or idle ant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!ant_req || ant_gnt) begin
      starve_cnt <= '0;
    end else if (rd_gnt) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict renderer priority; the limit only matters when the guard is built in
  assign starve_due = (STARVE_MAX < 0);
`endif

  // Sequencer state register and sticky fill-complete flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      init_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == ST_RUN) init_done <= 1'b1;
    end
  end

  // Next state plus RAM port steering; everything is quiet while rst is high
  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    rd_gnt     = 1'b0;
    ant_gnt    = 1'b0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          ram_en    = fill_wr_en;
          ram_we    = fill_wr_en;
          ram_addr  = fill_addr;
          ram_wdata = fill_tile;
          if (fill_done) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (rd_req && !starve_due) begin
            rd_gnt   = 1'b1;
            ram_en   = 1'b1;
            ram_addr = rd_addr;
          end else if (ant_req) begin
            ant_gnt   = 1'b1;
            ram_en    = 1'b1;
            ram_we    = ant_we;
            ram_addr  = ant_addr;
            ram_wdata = ant_wdata;
          end
        end
      endcase
    end
  end

  // Tag the owner of next cycle's read data; ant writes return nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else if (rd_gnt) begin
      owner <= OWN_RD;
    end else if (ant_gnt && !ant_we) begin
      owner <= OWN_ANT;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign rd_valid  = (owner == OWN_RD);
  assign ant_valid = (owner == OWN_ANT);
  assign rd_data   = rd_valid  ? ram_rdata : 3'd0;
  assign ant_rdata = ant_valid ? ram_rdata : 3'd0;

endmodule

// File: doc/tile_map_arbiter.md
# tile_map_arbiter

- Owns the single-port tile map RAM that stores one 3-bit tile code per grid cell.
- After reset it sequences a scenario fill of the whole map: air sky, ground line, dirt below, wall columns, one queen cell.
- It then shares the RAM between two requesters:
  - the VGA tile renderer, read-only and real-time, with priority;
  - the ant update engine, read or write.
- It sits between the tile RAM and the renderer/colour-lookup path, upstream of the tile-to-RGB333 colour mapping.

## Interface

- MAP_W, 32, grid columns (≥3)
- MAP_H, 24, grid rows
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W ≥ MAP_W*MAP_H
- GROUND_ROW, 8, row holding the ground line (0 < GROUND_ROW < MAP_H-1)
- STARVE_MAX, 4, consecutive renderer wins tolerated while the ant engine waits
- clk in 1 — single clock, rising edge
- rst in 1 — synchronous, active-high reset
- ram_en out 1 — RAM access strobe
- ram_we out 1 — RAM write enable
- ram_addr out ADDR_W — RAM address
- ram_wdata out 3 — RAM write tile code
- ram_rdata in 3 — RAM read data, valid one cycle after a read access
- rd_req in 1 — renderer read request
- rd_addr in ADDR_W — renderer address
- rd_gnt out 1 — renderer access accepted this cycle
- rd_valid out 1 — rd_data valid
- rd_data out 3 — renderer tile code
- ant_req in 1 — ant engine request
- ant_we in 1 — 1 = write, 0 = read
- ant_addr in ADDR_W — ant engine address
- ant_wdata in 3 — ant engine write data
- ant_gnt out 1 — ant access accepted this cycle
- ant_valid out 1 — ant_rdata valid (reads only)
- ant_rdata out 3 — ant read tile code
- init_done out 1 — fill complete; arbitration active

## Operation

- Tile codes: empty 0, air 1, dirt 2, ground 3, queen 4, wall 5, error 6, tunnel 7.
- FSM states: INIT, RUN. Reset enters INIT with row=0 and col=0.
- INIT:
  - Every cycle writes one cell: ram_en=1, ram_we=1, ram_addr=row*MAP_W+col. The address is kept as an incrementing counter; no multiplier.
  - Tile precedence:
    1. col==0 or col==MAP_W-1 → wall;
    2. row==GROUND_ROW+1 and col==MAP_W/2 → queen;
    3. row<GROUND_ROW → air;
    4. row==GROUND_ROW → ground;
    5. otherwise dirt.
  - col increments each cycle. When col wraps to 0, row increments.
  - After the write of (MAP_H-1, MAP_W-1), the FSM goes to RUN.
  - rd_gnt and ant_gnt are held at 0 throughout INIT; requests are ignored, not queued.
- RUN:
  - If rd_req is high and the starve guard is not due, the renderer is granted.
  - Otherwise, if ant_req is high, the ant engine is granted.
  - A grant drives the ram_* signals combinationally from the winner's inputs in the same cycle.
  - ram_we=0 for renderer grants; ram_we=ant_we for ant grants.
  - When no request is present, ram_en=0.
- Handshake:
  - A requester holds req, address and data stable until it sees gnt.
  - gnt is a single-cycle acceptance per access. Back-to-back accesses are allowed every cycle.
- Read return: a read granted in cycle N returns valid=1 and data=ram_rdata in cycle N+1, routed by a registered owner tag. Ant writes produce no ant_valid.

## Timing

- Reset values:
  - registered: state=INIT, row/col/address counters 0, rd_valid=0, ant_valid=0, init_done=0, starve counter 0;
  - combinational in the reset cycle: ram_en, ram_we, rd_gnt and ant_gnt all forced to 0.
- Fill takes exactly MAP_W*MAP_H cycles from the first cycle after rst falls.
- init_done is registered. It rises in the first RUN cycle and then stays 1 until reset.
- Read latency is 1 cycle. Throughput is 1 access per cycle in total.
- Simultaneous rd_req and ant_req: the renderer wins unless the starve guard is due.
- rst asserted mid-operation:
  - next cycle is INIT from cell 0;
  - pending valids are dropped (0 next cycle);
  - the starve counter is cleared.
- ram_rdata is ignored in any cycle with no tagged read outstanding.

## Configuration

- TILE_ARB_STARVE_EN defined:
  - The starve counter increments on each renderer grant made while ant_req=1.
  - When it equals STARVE_MAX, the next cycle with ant_req=1 grants the ant engine even if rd_req=1.
  - The counter clears on any ant grant and in any cycle with ant_req=0.
- TILE_ARB_STARVE_EN undefined: strict renderer priority; no counter logic.

## Structure

- Shared package `antfarm_pkg`: tile code localparams (empty … tunnel) and the owner-tag encoding (NONE, RD, ANT).
- Sub-module `tile_map_filler`:
  - Contents: INIT row/col/address counters and the tile precedence function.
  - Outputs: wr_en, wr_addr, wr_tile, done.
- Arbitration, owner tag and starve counter live in the top module.

## Test plan

- Reset with defaults, run to init_done:
  - exactly 768 writes occur;
  - cell 0 = wall, cell 1 = air, cell 8*32+5 = ground, cell 9*32+16 = queen, cell 767 = wall;
  - init_done rises at cycle 768.
- RUN, rd_req only, rd_addr=33 → rd_gnt that cycle; rd_valid=1 next cycle with rd_data=1 (air).
- Ant write:
  - ant write addr=300, data=7 → ant_gnt=1, ram_we=1, no ant_valid;
  - ant read addr=300 → ant_valid next cycle with ant_rdata=7.
- rd_req and ant_req held high continuously:
  - with TILE_ARB_STARVE_EN: pattern 4 renderer grants, 1 ant grant, repeating;
  - without it: ant_gnt stays 0.
- Reset pulse:
  - pulse rst at fill cell 100 → fill restarts at address 0; init_done=0; completes 768 cycles later.
  - pulse rst in the cycle after a RUN read grant → rd_valid=0 in the cycle following the reset.
- Requests during INIT → no grants, ram_we stays 1 on fill addresses only.
